// File: rtl/dmem_responder.sv
// Data-memory slave with a wait-state ready handshake and a write-log FIFO of committed stores.
// Optional macro DMEM_PRELOAD_EN: memory keeps its contents across reset instead of clearing.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned LOG_DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memreq,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  output logic                       ready,
  output logic [31:0]                readdata,
  output logic                       misaligned,
  output logic                       log_valid,
  output logic [31:0]                log_addr,
  output logic [31:0]                log_data,
  input  logic                       log_pop,
  output logic [$clog2(LOG_DEPTH):0] log_count,
  output logic                       log_overflow
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned PtrW = $clog2(LOG_DEPTH);
  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  localparam logic [PtrW:0] LogFull = (PtrW + 1)'(LOG_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_adr_q, req_adr_d;
  logic [31:0] req_wd_q, req_wd_d;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [IdxW-1:0] req_idx;
  logic            req_misaligned;
  logic            in_resp;
  logic            mem_we;

  // Request FSM
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_we_d   = req_we_q;
    req_adr_d  = req_adr_q;
    req_wd_d   = req_wd_q;
    unique case (state_q)
      StIdle: begin
        if (memreq) begin
          req_we_d   = memwrite;
          req_adr_d  = dataadr;
          req_wd_d   = writedata;
          wait_cnt_d = '0;
          state_d    = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_q == WaitLast) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      req_we_q   <= 1'b0;
      req_adr_q  <= '0;
      req_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_we_q   <= req_we_d;
      req_adr_q  <= req_adr_d;
      req_wd_q   <= req_wd_d;
    end
  end

  // Upper address bits are dropped, so addresses alias modulo the memory size.
  always_comb begin
    req_idx        = req_adr_q[IdxW+1:2];
    req_misaligned = req_adr_q[1:0] != 2'b00;
    in_resp        = state_q == StResp;
    mem_we         = in_resp && req_we_q && !req_misaligned;
    ready          = in_resp;
    misaligned     = in_resp && req_misaligned;
    readdata       = (in_resp && !req_we_q && !req_misaligned) ? mem_q[req_idx] : '0;
  end

`ifdef DMEM_PRELOAD_EN
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[req_idx] <= req_wd_q;
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[req_idx] <= req_wd_q;
    end
  end
`endif

  // Write-log FIFO
  logic [31:0]     log_addr_q [LOG_DEPTH];
  logic [31:0]     log_data_q [LOG_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, full;

  always_comb begin
    full       = count_q == LogFull;
    pop        = log_pop && (count_q != '0);
    // When full, a simultaneous pop frees the slot the push lands in.
    push       = mem_we && (!full || pop);
    overflow_d = overflow_q || (mem_we && !push);
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + (PtrW + 1)'(1);
    else if (pop && !push) count_d = count_q - (PtrW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      log_addr_q[wr_ptr_q] <= req_adr_q;
      log_data_q[wr_ptr_q] <= req_wd_q;
    end
  end

  always_comb begin
    log_valid    = count_q != '0;
    log_addr     = log_valid ? log_addr_q[rd_ptr_q] : '0;
    log_data     = log_valid ? log_data_q[rd_ptr_q] : '0;
    log_count    = count_q;
    log_overflow = overflow_q;
  end

endmodule
